// File: rtl/pipe_stage_fifo.sv
// Pipeline stage register generalised to a DEPTH-entry in-order buffer with
// valid/allow_in handshake, stage-local ready_go stall and synchronous flush.
module pipe_stage_fifo #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned DEPTH           = 2,
  parameter bit          CLEAR_ON_BUBBLE = 1'b1,
  localparam int unsigned CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_allow_in,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ready_go,
  output logic              out_valid,
  input  logic              out_allow_in,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  // Explicit wrap so non-power-of-two depths stay in range
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign full        = (cnt == FULL_CNT);
  assign empty       = (cnt == '0);
  assign count       = cnt;
  assign out_valid   = ~empty;
  assign pop         = out_valid & ready_go & out_allow_in;
  assign in_allow_in = ~full | pop;
  assign push        = in_valid & in_allow_in & ~flush;
  assign head        = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  generate
    if (CLEAR_ON_BUBBLE) begin : g_clear
      assign out_data = empty ? '0 : head;
    end else begin : g_hold
      // rd_ptr has moved past the last head once drained, so keep a copy of it
      logic [DATA_W-1:0] hold_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)        hold_q <= '0;
        else if (!empty) hold_q <= head;
      end
      assign out_data = empty ? hold_q : head;
    end
  endgenerate

endmodule

// File: doc/pipe_stage_fifo.md
Name: pipe_stage_fifo

Overview:
Generalised pipeline stage register for the CPU pipeline. It replaces the single-entry valid/allow_in stage latch with a DEPTH-entry in-order buffer that carries an opaque DATA_W payload (opcode, rd, valE, valM, pc, trace fields packed by the instantiating stage). It adds a stage-local ready_go stall, a synchronous flush, and an optional bubble-zeroing mode for the commit/trace interface. It sits between any two stages (e.g. memory_access -> write_back) and keeps the codebase's valid/allow_in handshake semantics.

Parameters:
DATA_W, 32, payload width in bits (>=1)
DEPTH, 2, buffer entries (>=1); DEPTH=1 behaves as the classic single stage latch
CLEAR_ON_BUBBLE, 1, 1: out_data forced to 0 when out_valid=0; 0: out_data holds the last head value
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream has a valid item (X_to_Y_valid)
in_allow_in  output  1  this stage accepts an item this cycle
in_data  input  DATA_W  upstream payload
ready_go  input  1  head item may leave this cycle (stage-local stall when 0)
out_valid  output  1  head item valid toward downstream
out_allow_in  input  1  downstream accepts this cycle
out_data  output  DATA_W  head payload
flush  input  1  discard all buffered items (branch mispredict / exception)
count  output  CNT_W  current occupancy
full  output  1  count==DEPTH
empty  output  1  count==0

Behaviour:
- Reset (rst=0, asynchronous): count=0, rd/wr pointers=0, out_valid=0, full=0, empty=1, in_allow_in=1 immediately; storage contents not reset. out_data=0 if CLEAR_ON_BUBBLE=1. Deassertion is synchronised externally; the first edge after release may push.
- pop = out_valid & ready_go & out_allow_in.
- push = in_valid & in_allow_in & ~flush.
- in_allow_in = ~full | pop (combinational pass-through; the same-cycle push+pop at full is legal, matching the codebase's allow_in chain).
- out_valid = ~empty (combinational from count). out_data = storage[rd_ptr] when ~empty.
- Latency: item pushed at edge N is visible on out_data/out_valid after edge N (one cycle), provided it is the head.
- Order: strict FIFO; no reordering, no duplication, no loss except flush.
- Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
- count update: push&~pop +1; pop&~push -1; both or neither: unchanged.
- Simultaneous push+pop when empty is impossible (out_valid=0, so pop=0). Push at empty: count becomes 1.
- flush=1 at an edge: count=0, rd_ptr=wr_ptr=0; the same-cycle push is dropped. A same-cycle pop still occurs as seen by downstream because out_valid was 1 combinationally. Downstream must gate on its own flush.
- ready_go=0 holds the head; out_valid stays 1 and out_data stays stable.
- Storage write occurs only on push; no write enable on flush.
- Invariants for verification: count<=DEPTH; full&empty never both 1; out_data stable while out_valid & ~pop.

Test Plan:
1. Reset mid-stream: DEPTH=2, push 0xA1, 0xA2 (full=1), drop rst low between edges -> out_valid=0, count=0, empty=1, out_data=0 immediately, without waiting for a clock edge.
2. Fill/drain: DEPTH=4, out_allow_in=0, push 0x11..0x14 -> full=1, in_allow_in=0, count=4; a 5th push of 0x15 is refused. Set out_allow_in=1 -> out_data 0x11,0x12,0x13,0x14 on consecutive cycles, then empty=1.
3. Full push+pop: DEPTH=2 full with 0x21,0x22; in_valid=1 data 0x23, ready_go=1, out_allow_in=1 -> in_allow_in=1, count stays 2, next head 0x22, then 0x23.
4. Stall: head 0x31, ready_go=0 for 3 cycles with out_allow_in=1 -> out_valid=1, out_data=0x31 held, count unchanged; ready_go=1 -> 0x31 popped once.
5. Flush with push: count=3 (DEPTH=4), flush=1 with in_valid=1 data 0x41 -> next cycle count=0, empty=1, out_valid=0; 0x41 never appears on out_data.
6. Wrap and modes: DEPTH=3, stream 10 items 0x50..0x59 with random out_allow_in -> output order is exact. With CLEAR_ON_BUBBLE=0, the last value is held on out_data after draining; with CLEAR_ON_BUBBLE=1, out_data=0.
